// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Grants are held for a burst of up to MAX_BURST beats; writes are paced one per two cycles.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CW = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  fifo_full_n,
    output logic                  fifo_in_valid,
    output logic [DW-1:0]         fifo_di,
    output logic [IW-1:0]         fifo_src,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 fifo_in_valid_q, fifo_in_valid_d;
    logic [DW-1:0]        fifo_di_q, fifo_di_d;
    logic [IW-1:0]        fifo_src_q, fifo_src_d;
    logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]        last_idx_q, last_idx_d;
    logic [IW-1:0]        owner_q, owner_d;

    logic                 found;
    logic [IW-1:0]        pick;
    logic [DW-1:0]        sel_data;
    logic                 sel_last;
    logic                 beat_acc;
    logic [CW-1:0]        cnt_inc;

    // The ~fifo_in_valid term leaves a gap so the registered full flag is seen before each beat.
    always_comb begin
        req_ready = '0;
        if (state_q == StBurst && fifo_full_n && !fifo_in_valid_q) begin
            req_ready = grant_q;
        end
    end

    assign beat_acc = |(req_valid & req_ready);
    assign sel_last = |(req_last & grant_q);
    assign cnt_inc  = beat_cnt_q + CW'(1);

    // Round-robin: first requester above last_idx, otherwise lowest index overall (wrap).
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req_valid[i] && (IW'(i) > last_idx_q)) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (owner_q == IW'(i)) begin
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        busy_d          = busy_q;
        fifo_in_valid_d = 1'b0;
        fifo_di_d       = fifo_di_q;
        fifo_src_d      = fifo_src_q;
        beat_cnt_d      = beat_cnt_q;
        last_idx_d      = last_idx_q;
        owner_d         = owner_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        grant_d[i] = (IW'(i) == pick);
                    end
                    owner_d    = pick;
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (beat_acc) begin
                    fifo_in_valid_d = 1'b1;
                    fifo_di_d       = sel_data;
                    fifo_src_d      = owner_q;
                    beat_cnt_d      = cnt_inc;
                    if (sel_last || (cnt_inc == CW'(MAX_BURST))) begin
                        state_d    = StIdle;
                        grant_d    = '0;
                        busy_d     = 1'b0;
                        last_idx_d = owner_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            grant_q         <= '0;
            busy_q          <= 1'b0;
            fifo_in_valid_q <= 1'b0;
            fifo_di_q       <= '0;
            fifo_src_q      <= '0;
            beat_cnt_q      <= '0;
            last_idx_q      <= IW'(NUM_REQ - 1);
            owner_q         <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            busy_q          <= busy_d;
            fifo_in_valid_q <= fifo_in_valid_d;
            fifo_di_q       <= fifo_di_d;
            fifo_src_q      <= fifo_src_d;
            beat_cnt_q      <= beat_cnt_d;
            last_idx_q      <= last_idx_d;
            owner_q         <= owner_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = busy_q;
    assign fifo_in_valid = fifo_in_valid_q;
    assign fifo_di       = fifo_di_q;
    assign fifo_src      = fifo_src_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: producer models feed beats, a queue of expected
// {src, data} writes is checked against every fifo_in_valid pulse.
module tb_fifo_write_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full_n;
    logic              fifo_in_valid;
    logic [DW-1:0]     fifo_di;
    logic [0:0]        fifo_src;
    logic [NR-1:0]     grant;
    logic              busy;

    fifo_write_arbiter #(.NUM_REQ(NR), .DW(DW), .MAX_BURST(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_full_n   (fifo_full_n),
        .fifo_in_valid (fifo_in_valid),
        .fifo_di       (fifo_di),
        .fifo_src      (fifo_src),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic prev_fv = 1'b0;

    logic [DW-1:0] pdata [NR][8];
    logic          plast [NR][8];
    int            pn [NR];
    int            pp [NR];

    logic [DW:0]   exp_q [$];
    int            wr_cyc [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (pp[i] < pn[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pdata[i][pp[i]];
                req_last[i]           = plast[i][pp[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input logic [DW-1:0] d, input logic l);
        pdata[r][pn[r]] = d;
        plast[r][pn[r]] = l;
        pn[r]++;
        drive();
    endtask

    task automatic expect_wr(input logic s, input logic [DW-1:0] d);
        exp_q.push_back({s, d});
    endtask

    // One clock: sample handshake mid-cycle, then observe registered outputs just after the edge.
    task automatic step();
        logic [NR-1:0] acc;
        logic [DW:0]   e;
        #4;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (fifo_in_valid) begin
            wr_cyc.push_back(cyc);
            check("pacing_gap", {63'd0, prev_fv}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, fifo_src, fifo_di}, 64'h1_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_src_data", {31'd0, fifo_src, fifo_di}, {31'd0, e});
            end
        end
        prev_fv = fifo_in_valid;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) pp[i]++;
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, {62'd0, grant}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_fv"}, {63'd0, fifo_in_valid}, 64'd0);
        check({tag, "_di"}, {32'd0, fifo_di}, 64'd0);
        check({tag, "_src"}, {63'd0, fifo_src}, 64'd0);
        check({tag, "_ready"}, {62'd0, req_ready}, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pn[i] = 0;
            pp[i] = 0;
        end
        fifo_full_n = 1'b1;
        exp_q.delete();
        drive();
        #1;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        prev_fv = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        fifo_full_n = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        for (int i = 0; i < NR; i++) begin
            pn[i] = 0;
            pp[i] = 0;
        end

        // Single request with last
        do_reset();
        load(0, 32'hA5A5_0001, 1'b1);
        expect_wr(1'b0, 32'hA5A5_0001);
        #1;
        check("idle_ready", {62'd0, req_ready}, 64'd0);
        step();
        check("single_grant", {62'd0, grant}, 64'd1);
        check("single_busy", {63'd0, busy}, 64'd1);
        check("single_ready", {62'd0, req_ready}, 64'd1);
        step();
        check("single_fv", {63'd0, fifo_in_valid}, 64'd1);
        check("single_release_busy", {63'd0, busy}, 64'd0);
        check("single_release_grant", {62'd0, grant}, 64'd0);
        run(4);
        check("single_drain", exp_q.size(), 64'd0);

        // Round-robin, every beat last
        do_reset();
        load(0, 32'h0000_0010, 1'b1);
        load(0, 32'h0000_0011, 1'b1);
        load(1, 32'h0000_0020, 1'b1);
        load(1, 32'h0000_0021, 1'b1);
        expect_wr(1'b0, 32'h0000_0010);
        expect_wr(1'b1, 32'h0000_0020);
        expect_wr(1'b0, 32'h0000_0011);
        expect_wr(1'b1, 32'h0000_0021);
        run(20);
        check("rr_drain", exp_q.size(), 64'd0);
        check("rr_idle", {63'd0, busy}, 64'd0);

        // Burst cap: requester 1 owns first, 6 beats without last
        do_reset();
        for (int k = 0; k < 6; k++) load(1, 32'h0000_0030 + k, 1'b0);
        step();
        check("cap_first_grant", {62'd0, grant}, 64'd2);
        load(0, 32'h0000_0040, 1'b0);
        load(0, 32'h0000_0041, 1'b1);
        for (int k = 0; k < 4; k++) expect_wr(1'b1, 32'h0000_0030 + k);
        expect_wr(1'b0, 32'h0000_0040);
        expect_wr(1'b0, 32'h0000_0041);
        expect_wr(1'b1, 32'h0000_0034);
        expect_wr(1'b1, 32'h0000_0035);
        run(30);
        check("cap_drain", exp_q.size(), 64'd0);
        check("cap_held_grant", {62'd0, grant}, 64'd2);
        check("cap_held_busy", {63'd0, busy}, 64'd1);

        // Backpressure mid-burst
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load(0, 32'h0000_0050 + k, k == 3);
            expect_wr(1'b0, 32'h0000_0050 + k);
        end
        run(2);
        fifo_full_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_ready", {62'd0, req_ready}, 64'd0);
            check("bp_grant", {62'd0, grant}, 64'd1);
        end
        check("bp_pending", exp_q.size(), 64'd3);
        fifo_full_n = 1'b1;
        run(15);
        check("bp_drain", exp_q.size(), 64'd0);

        // Pacing: 4-beat burst with full_n tied high
        do_reset();
        wr_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            load(0, 32'h0000_0060 + k, k == 3);
            expect_wr(1'b0, 32'h0000_0060 + k);
        end
        run(15);
        check("pace_count", wr_cyc.size(), 64'd4);
        if (wr_cyc.size() == 4) begin
            for (int k = 1; k < 4; k++) begin
                check("pace_interval", wr_cyc[k] - wr_cyc[k-1], 64'd2);
            end
        end

        // Reset mid-burst after beat 2 of 4
        do_reset();
        for (int k = 0; k < 4; k++) load(0, 32'h0000_0070 + k, k == 3);
        expect_wr(1'b0, 32'h0000_0070);
        expect_wr(1'b0, 32'h0000_0071);
        run(5);
        check("mid_written", exp_q.size(), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        pn[0] = 0;
        pp[0] = 0;
        drive();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        prev_fv = 1'b0;
        load(1, 32'h0000_0080, 1'b1);
        load(0, 32'h0000_0090, 1'b1);
        expect_wr(1'b0, 32'h0000_0090);
        expect_wr(1'b1, 32'h0000_0080);
        run(15);
        check("post_rst_drain", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
